// File: rtl/debug_sequencer.sv
// ---------------------------------------------------------------------------
// debug_sequencer
//
// Takes one host debug command at a time and walks it through CPU halt, op
// presentation to the debug op decoder, an optional bus wait and result
// capture. It then returns exactly one response per command.
//
// Optional feature (compile-time macro DEBUG_SEQ_TIMEOUT_EN):
//   A bus-wait watchdog. If BUS_DONE has not arrived after TIMEOUT_CYC cycles
//   in BUS_WAIT, the command completes with RSP_STATUS=01 and RSP_DATA=0.
//   Without the macro there is no counter, BUS_WAIT waits indefinitely and
//   RSP_STATUS is always 00.
//
// Ports:
//   CLK, RESETN          clock, asynchronous active-low reset
//   CMD_*                command channel (valid/ready) with op, argument,
//                        auto-increment, breakpoint enable, address load, data
//   HALT_REQ / HALTED    CPU halt request and acknowledge
//   DEBUG_OP/ARG/...     op, argument and qualifiers for the debug op decoder
//   DEBUG_ADDR/WDATA     debug address register and write data register
//   BUS_DONE/DEBUG_RDATA bus completion pulse and datapath read data
//   RSP_*                response channel (valid/ready) with data and status
// ---------------------------------------------------------------------------
module debug_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_STEP   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [2:0]        CMD_OP,
  input  logic [2:0]        CMD_ARG,
  input  logic              CMD_INC,
  input  logic              CMD_EN_BKP,
  input  logic              CMD_LD_ADDR,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              HALT_REQ,
  input  logic              HALTED,
  output logic [2:0]        DEBUG_OP,
  output logic [2:0]        DEBUG_ARG,
  output logic              DEBUG_ADDR_INC,
  output logic              DEBUG_EN_BKP,
  output logic [DATA_W-1:0] DEBUG_ADDR,
  output logic [DATA_W-1:0] DEBUG_WDATA,
  input  logic              BUS_DONE,
  input  logic [DATA_W-1:0] DEBUG_RDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic [1:0]        RSP_STATUS
);

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_WR_BKP   = 3'd1;
  localparam logic [2:0] OP_RD_REG   = 3'd2;
  localparam logic [2:0] OP_RD_CC    = 3'd3;
  localparam logic [2:0] OP_RD_PC    = 3'd4;
  localparam logic [2:0] OP_RD_INSTR = 3'd5;
  localparam logic [2:0] OP_RD_MEM   = 3'd6;
  localparam logic [2:0] OP_WR_MEM   = 3'd7;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b01;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    ISSUE     = 3'd2,
    BUS_WAIT  = 3'd3,
    CAPTURE   = 3'd4,
    RESPOND   = 3'd5
  } state_t;

  // Ops that need the bus sequencer before data is available.
  function automatic logic is_bus_op(input logic [2:0] op);
    return (op == OP_RD_INSTR) || (op == OP_RD_MEM) || (op == OP_WR_MEM);
  endfunction

  // Ops that advance DEBUG_ADDR when auto-increment is requested.
  function automatic logic is_inc_op(input logic [2:0] op);
    return (op == OP_RD_REG) || (op == OP_RD_CC) || (op == OP_RD_PC) ||
           (op == OP_RD_MEM) || (op == OP_WR_MEM);
  endfunction

  // Write ops echo their write data instead of returning datapath data.
  function automatic logic is_echo_op(input logic [2:0] op);
    return (op == OP_WR_BKP) || (op == OP_WR_MEM);
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic                ready_r;
  logic                accept_s;
  logic                nop_done_s;
  logic                timeout_s;
  logic [2:0]          op_r;
  logic [2:0]          arg_r;
  logic                inc_r;
  logic                en_bkp_r;
  logic [DATA_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                halt_req_r;
  logic [2:0]          debug_op_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic [1:0]          rsp_status_r;

  // ready_r comes out of reset low and rises one edge later, so a command
  // held valid through reset is never taken in the reset cycle.
  assign accept_s   = CMD_VALID & ready_r;
  assign nop_done_s = (state_r == HALT_WAIT) && HALTED && (op_r == OP_NOP);

`ifdef DEBUG_SEQ_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] bus_cnt_r;

  // Bus-wait cycle counter: zero outside BUS_WAIT, so it is clear on entry.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bus_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != BUS_WAIT) begin
      bus_cnt_r <= {CNT_W{1'b0}};
    end else begin
      bus_cnt_r <= bus_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic [31:0] timeout_unused_s;
  assign timeout_unused_s = 32'(TIMEOUT_CYC);
`endif

  // Next-state logic and the bus-wait timeout decision.
  always_comb begin
    state_s   = state_r;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = HALT_WAIT;
        else          state_s = IDLE;
      end
      HALT_WAIT: begin
        if (!HALTED)               state_s = HALT_WAIT;
        else if (op_r == OP_NOP)   state_s = RESPOND;
        else                       state_s = ISSUE;
      end
      ISSUE: begin
        if (is_bus_op(op_r)) state_s = BUS_WAIT;
        else                 state_s = CAPTURE;
      end
      BUS_WAIT: begin
        // BUS_DONE wins over a timeout landing on the same cycle.
        if (BUS_DONE) begin
          state_s = CAPTURE;
        end else begin
`ifdef DEBUG_SEQ_TIMEOUT_EN
          // bus_cnt_r holds the number of BUS_WAIT cycles already completed,
          // so this is the TIMEOUT_CYC-th cycle.
          if (bus_cnt_r == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_s   = RESPOND;
            timeout_s = 1'b1;
          end else begin
            state_s = BUS_WAIT;
          end
`else
          state_s = BUS_WAIT;
`endif
        end
      end
      CAPTURE: begin
        state_s = RESPOND;
      end
      RESPOND: begin
        if (RSP_READY) state_s = IDLE;
        else           state_s = RESPOND;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus the registered handshake and op-presentation outputs.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_r     <= IDLE;
      ready_r     <= 1'b0;
      debug_op_r  <= 3'd0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ready_r     <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RESPOND);
      if ((state_s == ISSUE) || (state_s == BUS_WAIT) || (state_s == CAPTURE)) begin
        debug_op_r <= op_r;
      end else begin
        debug_op_r <= OP_NOP;
      end
    end
  end

  // Command latch; the address load happens on the accepting edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      op_r     <= 3'd0;
      arg_r    <= 3'd0;
      inc_r    <= 1'b0;
      en_bkp_r <= 1'b0;
      wdata_r  <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_r     <= CMD_OP;
      arg_r    <= CMD_ARG;
      inc_r    <= CMD_INC;
      en_bkp_r <= CMD_EN_BKP;
      wdata_r  <= CMD_DATA;
    end else begin
      op_r     <= op_r;
      arg_r    <= arg_r;
      inc_r    <= inc_r;
      en_bkp_r <= en_bkp_r;
      wdata_r  <= wdata_r;
    end
  end

  // Debug address register: host load on accept, auto-increment in CAPTURE.
  // A timed-out command never reaches CAPTURE, so it leaves the address alone.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      addr_r <= {DATA_W{1'b0}};
    end else if (accept_s && CMD_LD_ADDR) begin
      addr_r <= CMD_DATA;
    end else if ((state_r == CAPTURE) && inc_r && is_inc_op(op_r)) begin
      addr_r <= addr_r + DATA_W'(ADDR_STEP);
    end else begin
      addr_r <= addr_r;
    end
  end

  // Halt request: raised on accept, held until the response handshake.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      halt_req_r <= 1'b0;
    end else if (accept_s) begin
      halt_req_r <= 1'b1;
    end else if ((state_r == RESPOND) && RSP_READY) begin
      halt_req_r <= 1'b0;
    end else begin
      halt_req_r <= halt_req_r;
    end
  end

  // Response payload: written only on the way into RESPOND, then held.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rsp_data_r   <= {DATA_W{1'b0}};
      rsp_status_r <= STATUS_OK;
    end else if (state_r == CAPTURE) begin
      rsp_data_r   <= is_echo_op(op_r) ? wdata_r : DEBUG_RDATA;
      rsp_status_r <= STATUS_OK;
    end else if (nop_done_s) begin
      rsp_data_r   <= {DATA_W{1'b0}};
      rsp_status_r <= STATUS_OK;
    end else if (timeout_s) begin
      rsp_data_r   <= {DATA_W{1'b0}};
      rsp_status_r <= STATUS_TIMEOUT;
    end else begin
      rsp_data_r   <= rsp_data_r;
      rsp_status_r <= rsp_status_r;
    end
  end

  assign CMD_READY      = ready_r;
  assign HALT_REQ       = halt_req_r;
  assign DEBUG_OP       = debug_op_r;
  assign DEBUG_ARG      = arg_r;
  assign DEBUG_ADDR_INC = inc_r;
  assign DEBUG_EN_BKP   = en_bkp_r;
  assign DEBUG_ADDR     = addr_r;
  assign DEBUG_WDATA    = wdata_r;
  assign RSP_VALID      = rsp_valid_r;
  assign RSP_DATA       = rsp_data_r;
  assign RSP_STATUS     = rsp_status_r;

endmodule

// File: tb/tb_debug_sequencer.sv
// ---------------------------------------------------------------------------
// tb_debug_sequencer
//
// Directed bench for debug_sequencer. The stimulus thread pushes the expected
// {status, data} of every command into exp_q. A monitor pops one entry on
// each response handshake and compares it. The stimulus thread also checks
// cycle-level behaviour (op presentation, halt, address register) directly.
// ---------------------------------------------------------------------------
module tb_debug_sequencer;

`ifdef DEBUG_SEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 10;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [2:0]  CMD_OP;
  logic [2:0]  CMD_ARG;
  logic        CMD_INC;
  logic        CMD_EN_BKP;
  logic        CMD_LD_ADDR;
  logic [15:0] CMD_DATA;
  logic        HALT_REQ;
  logic        HALTED;
  logic [2:0]  DEBUG_OP;
  logic [2:0]  DEBUG_ARG;
  logic        DEBUG_ADDR_INC;
  logic        DEBUG_EN_BKP;
  logic [15:0] DEBUG_ADDR;
  logic [15:0] DEBUG_WDATA;
  logic        BUS_DONE;
  logic [15:0] DEBUG_RDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [15:0] RSP_DATA;
  logic [1:0]  RSP_STATUS;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [17:0] exp_q[$];

  always #5 CLK = ~CLK;

  debug_sequencer #(.DATA_W(16), .ADDR_STEP(2), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .CLK(CLK), .RESETN(RESETN),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_ARG(CMD_ARG), .CMD_INC(CMD_INC), .CMD_EN_BKP(CMD_EN_BKP),
    .CMD_LD_ADDR(CMD_LD_ADDR), .CMD_DATA(CMD_DATA),
    .HALT_REQ(HALT_REQ), .HALTED(HALTED),
    .DEBUG_OP(DEBUG_OP), .DEBUG_ARG(DEBUG_ARG), .DEBUG_ADDR_INC(DEBUG_ADDR_INC),
    .DEBUG_EN_BKP(DEBUG_EN_BKP), .DEBUG_ADDR(DEBUG_ADDR), .DEBUG_WDATA(DEBUG_WDATA),
    .BUS_DONE(BUS_DONE), .DEBUG_RDATA(DEBUG_RDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_STATUS(RSP_STATUS)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Response monitor: one scoreboard entry per handshake.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL rsp_unexpected: got data %h status %b, required no response",
                   RSP_DATA, RSP_STATUS);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", {16'd0, RSP_DATA}, {16'd0, e[15:0]});
          chk("rsp_status", {30'd0, RSP_STATUS}, {30'd0, e[17:16]});
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required run completion");
    $fatal(1, "watchdog");
  end

  // Present one command; returns on the negedge of the first cycle after accept.
  task automatic send(input logic [2:0] op, input logic [2:0] arg, input logic inc,
                      input logic bkp, input logic ld, input logic [15:0] data);
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("send_ready", {31'd0, CMD_READY}, 32'd1);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_ARG = arg; CMD_INC = inc;
    CMD_EN_BKP = bkp; CMD_LD_ADDR = ld; CMD_DATA = data;
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  // Bus model: pulse BUS_DONE n cycles after the op is first presented (ISSUE).
  task automatic do_bus(input int n);
    int k = 0;
    while (DEBUG_OP == 3'd0 && k < 50) begin
      @(negedge CLK);
      k++;
    end
    repeat (n) @(negedge CLK);
    BUS_DONE = 1'b1;
    @(negedge CLK);
    BUS_DONE = 1'b0;
  endtask

  // Wait until every expected response was seen and the sequencer is idle again.
  task automatic wait_idle();
    int n = 0;
    while (!(CMD_READY === 1'b1 && exp_q.size() == 0) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("idle_reached", {31'd0, (CMD_READY === 1'b1 && exp_q.size() == 0)}, 32'd1);
  endtask

  initial begin
    RESETN = 1'b0; CMD_VALID = 1'b1; CMD_OP = 3'd2; CMD_ARG = 3'd0; CMD_INC = 1'b0;
    CMD_EN_BKP = 1'b0; CMD_LD_ADDR = 1'b0; CMD_DATA = 16'h0000; HALTED = 1'b1;
    BUS_DONE = 1'b0; DEBUG_RDATA = 16'h0000; RSP_READY = 1'b1;

    // Reset with a command held valid.
    repeat (3) @(negedge CLK);
    chk("reset_ctrl", {19'd0, CMD_READY, HALT_REQ, DEBUG_OP, DEBUG_ARG, DEBUG_ADDR_INC,
                       DEBUG_EN_BKP, RSP_VALID, RSP_STATUS}, 32'd0);
    chk("reset_data", {DEBUG_ADDR, DEBUG_WDATA}, 32'd0);
    chk("reset_rsp_data", {16'd0, RSP_DATA}, 32'd0);
    RESETN = 1'b1;
    @(negedge CLK);
    chk("ready_after_reset", {31'd0, CMD_READY}, 32'd1);
    chk("no_accept_in_reset", {31'd0, HALT_REQ}, 32'd0);
    CMD_VALID = 1'b0;
    @(negedge CLK);
    chk("still_idle", {30'd0, CMD_READY, HALT_REQ}, 32'd2);

    // RD_REG, ARG=3: op presented for ISSUE and CAPTURE, response on 4th cycle.
    DEBUG_RDATA = 16'h1234;
    exp_q.push_back({2'b00, 16'h1234});
    send(3'd2, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rdreg_c1_op", {29'd0, DEBUG_OP}, 32'd0);
    chk("rdreg_c1_valid", {31'd0, RSP_VALID}, 32'd0);
    @(negedge CLK);
    chk("rdreg_c2_op", {29'd0, DEBUG_OP}, 32'd2);
    chk("rdreg_c2_arg", {29'd0, DEBUG_ARG}, 32'd3);
    chk("rdreg_c2_valid", {31'd0, RSP_VALID}, 32'd0);
    @(negedge CLK);
    chk("rdreg_c3_op", {29'd0, DEBUG_OP}, 32'd2);
    chk("rdreg_c3_valid", {31'd0, RSP_VALID}, 32'd0);
    @(negedge CLK);
    chk("rdreg_c4_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("rdreg_c4_op", {29'd0, DEBUG_OP}, 32'd0);
    wait_idle();

    // Stray BUS_DONE in IDLE is ignored.
    BUS_DONE = 1'b1;
    @(negedge CLK);
    BUS_DONE = 1'b0;
    chk("stray_done_idle", {30'd0, CMD_READY, HALT_REQ}, 32'd2);

    // RD_MEM with address load 0xFFFE, INC: wraps to 0x0000.
    DEBUG_RDATA = 16'hBEEF;
    exp_q.push_back({2'b00, 16'hBEEF});
    send(3'd6, 3'd0, 1'b1, 1'b0, 1'b1, 16'hFFFE);
    chk("rdmem_addr_load", {16'd0, DEBUG_ADDR}, 32'h0000FFFE);
    @(negedge CLK);                       // ISSUE
    chk("rdmem_issue_op", {29'd0, DEBUG_OP}, 32'd6);
    @(negedge CLK);                       // BUS_WAIT 1
    chk("rdmem_buswait_op", {29'd0, DEBUG_OP}, 32'd6);
    @(negedge CLK);                       // BUS_WAIT 2
    @(negedge CLK);                       // BUS_WAIT 3
    BUS_DONE = 1'b1;
    @(negedge CLK);                       // CAPTURE
    BUS_DONE = 1'b0;
    chk("rdmem_capture_addr", {16'd0, DEBUG_ADDR}, 32'h0000FFFE);
    @(negedge CLK);                       // RESPOND
    chk("rdmem_addr_wrap", {16'd0, DEBUG_ADDR}, 32'h00000000);
    chk("rdmem_valid", {31'd0, RSP_VALID}, 32'd1);
    wait_idle();

    // WR_MEM with HALTED low for 5 cycles.
    HALTED = 1'b0;
    exp_q.push_back({2'b00, 16'hA55A});
    send(3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 16'hA55A);
    chk("wrmem_wdata", {16'd0, DEBUG_WDATA}, 32'h0000A55A);
    for (int i = 0; i < 5; i++) begin
      chk("wrmem_halt_req", {31'd0, HALT_REQ}, 32'd1);
      chk("wrmem_wait_op", {29'd0, DEBUG_OP}, 32'd0);
      if (i < 4) @(negedge CLK);
    end
    HALTED = 1'b1;
    do_bus(2);
    wait_idle();
    chk("wrmem_addr_same", {16'd0, DEBUG_ADDR}, 32'd0);

    // RD_PC with RSP_READY low 3 cycles; a second command waits for handshake.
    RSP_READY = 1'b0;
    DEBUG_RDATA = 16'h7E57;
    exp_q.push_back({2'b00, 16'h7E57});
    send(3'd4, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int n = 0; n < 20 && RSP_VALID !== 1'b1; n++) @(negedge CLK);
    DEBUG_RDATA = 16'hFFFF;
    CMD_VALID = 1'b1; CMD_OP = 3'd0; CMD_ARG = 3'd0; CMD_INC = 1'b0;
    CMD_LD_ADDR = 1'b0; CMD_DATA = 16'h0000;
    exp_q.push_back({2'b00, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, RSP_VALID}, 32'd1);
      chk("stall_data", {16'd0, RSP_DATA}, 32'h00007E57);
      chk("stall_busy", {30'd0, CMD_READY, HALT_REQ}, 32'd1);
      @(negedge CLK);
    end
    RSP_READY = 1'b1;
    chk("hs_cycle_not_ready", {31'd0, CMD_READY}, 32'd0);
    @(negedge CLK);
    chk("after_hs_ready", {31'd0, CMD_READY}, 32'd1);
    chk("after_hs_valid", {31'd0, RSP_VALID}, 32'd0);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    chk("second_accepted", {30'd0, CMD_READY, HALT_REQ}, 32'd1);
    wait_idle();

    // Reset in BUS_WAIT aborts without a response.
    send(3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge CLK);
    RESETN = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, HALT_REQ, DEBUG_OP, RSP_VALID}, 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_no_rsp", {30'd0, RSP_VALID, HALT_REQ}, 32'd0);
    wait_idle();

    // WR_BKP: echo, qualifiers presented, no increment even with INC.
    exp_q.push_back({2'b00, 16'h0042});
    send(3'd1, 3'd2, 1'b1, 1'b1, 1'b0, 16'h0042);
    chk("bkp_quals", {27'd0, DEBUG_EN_BKP, DEBUG_ADDR_INC, DEBUG_ARG}, 32'h0000001A);
    wait_idle();
    chk("bkp_no_inc", {16'd0, DEBUG_ADDR}, 32'd0);

    // RD_CC with address load and increment.
    DEBUG_RDATA = 16'h00C3;
    exp_q.push_back({2'b00, 16'h00C3});
    send(3'd3, 3'd5, 1'b1, 1'b0, 1'b1, 16'h1000);
    wait_idle();
    chk("rdcc_inc", {16'd0, DEBUG_ADDR}, 32'h00001002);

    // RD_INSTR via the bus: never increments.
    DEBUG_RDATA = 16'h4E71;
    exp_q.push_back({2'b00, 16'h4E71});
    send(3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    do_bus(1);
    wait_idle();
    chk("rdinstr_no_inc", {16'd0, DEBUG_ADDR}, 32'h00001002);

`ifdef DEBUG_SEQ_TIMEOUT_EN
    // RD_INSTR with no BUS_DONE: timeout after 10 BUS_WAIT cycles.
    exp_q.push_back({2'b01, 16'h0000});
    send(3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (11) @(negedge CLK);
    chk("to_not_yet", {31'd0, RSP_VALID}, 32'd0);
    chk("to_op_held", {29'd0, DEBUG_OP}, 32'd5);
    @(negedge CLK);
    chk("to_valid", {31'd0, RSP_VALID}, 32'd1);
    chk("to_op_nop", {29'd0, DEBUG_OP}, 32'd0);
    chk("to_addr_same", {16'd0, DEBUG_ADDR}, 32'h00001002);
    wait_idle();
`endif

    chk("queue_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge CLK);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/debug_sequencer.md
Name: debug_sequencer

Overview:
- Sequences host debug commands into the debug op decoder, the bus sequencer and the CPU halt logic.
- Accepts one command at a time over a valid/ready handshake.
- Halts the CPU, presents the op for the required cycles and waits for bus completion.
- Captures result data and returns exactly one response per command.

Parameters:
- DATA_W, 16, width of data, address and response words.
- ADDR_STEP, 2, auto-increment step applied to DEBUG_ADDR.
- TIMEOUT_CYC, 255, bus-wait limit in cycles (timeout feature only).

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  3  op code: 0 NOP, 1 WR_BKP, 2 RD_REG, 3 RD_CC, 4 RD_PC, 5 RD_INSTR, 6 RD_MEM, 7 WR_MEM.
- CMD_ARG  in  3  op argument (register/cc select, PC next select).
- CMD_INC  in  1  auto-increment DEBUG_ADDR after the op.
- CMD_EN_BKP  in  1  breakpoint enable value for WR_BKP.
- CMD_LD_ADDR  in  1  load DEBUG_ADDR from CMD_DATA before the op.
- CMD_DATA  in  DATA_W  address or write data.
- HALT_REQ  out  1  request CPU halt.
- HALTED  in  1  CPU is halted.
- DEBUG_OP  out  3  op presented to the decoder.
- DEBUG_ARG  out  3  argument presented to the decoder.
- DEBUG_ADDR_INC  out  1  increment qualifier to the decoder.
- DEBUG_EN_BKP  out  1  breakpoint enable to the decoder.
- DEBUG_ADDR  out  DATA_W  debug address register.
- DEBUG_WDATA  out  DATA_W  write data register.
- BUS_DONE  in  1  bus sequencer completed a read/write (single-cycle pulse).
- DEBUG_RDATA  in  DATA_W  selected debug data from the datapath.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumer ready.
- RSP_DATA  out  DATA_W  response data.
- RSP_STATUS  out  2  00 OK, 01 TIMEOUT, 10 reserved, 11 reserved.

Behaviour:
- Reset values: all outputs 0. State IDLE. CMD_READY is 0 during reset and 1 in IDLE.
- Reset mid-operation aborts the command immediately. No response is produced. HALT_REQ drops.
- FSM states: IDLE, HALT_WAIT, ISSUE, BUS_WAIT, CAPTURE, RESPOND.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID&CMD_READY, latch OP, ARG, INC, EN_BKP and DATA into DEBUG_WDATA.
  - If CMD_LD_ADDR, DEBUG_ADDR<=CMD_DATA in the same edge.
  - Assert HALT_REQ and go to HALT_WAIT. CMD_READY=0 outside IDLE.
- HALT_REQ stays 1 from accept until RESPOND exits. It is never dropped mid-command.
- HALT_WAIT: while HALTED=0, stay. When HALTED=1, go to ISSUE, or go directly to RESPOND with data 0 if OP=NOP.
- DEBUG_OP is NOP (0) in every state except ISSUE, BUS_WAIT and CAPTURE, where it holds the latched op.
- ISSUE: one cycle.
  - Ops 5/6/7 go to BUS_WAIT.
  - Ops 1–4 go to CAPTURE.
- BUS_WAIT: wait for BUS_DONE. BUS_DONE in the same cycle as entry is not possible; the earliest accepted BUS_DONE is the first BUS_WAIT cycle. Then go to CAPTURE.
- CAPTURE: one cycle.
  - RSP_DATA<=DEBUG_RDATA for ops 2–6.
  - RSP_DATA<=DEBUG_WDATA for ops 1/7 (echo).
  - If INC=1 and op ∈ {2,3,4,6,7}, DEBUG_ADDR<=DEBUG_ADDR+ADDR_STEP, mod 2^DATA_W. Wrap 0xFFFE+2 -> 0x0000.
  - RSP_STATUS<=00. Go to RESPOND.
- RESPOND:
  - RSP_VALID=1. RSP_DATA and RSP_STATUS are held stable while RSP_VALID&!RSP_READY.
  - On RSP_READY: RSP_VALID<=0, HALT_REQ<=0, go to IDLE.
- Back-to-back commands: the earliest new accept is the cycle after response handshake (IDLE).
- Throughput, non-bus op with HALTED already 1 and RSP_READY=1: accept->RSP_VALID = 4 cycles (HALT_WAIT, ISSUE, CAPTURE, RESPOND).
- BUS_DONE outside BUS_WAIT is ignored.
- CMD_VALID while busy is ignored, because CMD_READY=0.

Optional Feature:
- Macro: DEBUG_SEQ_TIMEOUT_EN.
- Enabled:
  - 8-bit or wider counter clears on BUS_WAIT entry and counts each BUS_WAIT cycle.
  - On reaching TIMEOUT_CYC without BUS_DONE: go to RESPOND with RSP_DATA=0 and RSP_STATUS=01. DEBUG_ADDR is not incremented. DEBUG_OP returns to NOP.
  - BUS_DONE on the same cycle as the count reaching TIMEOUT_CYC counts as success.
- Disabled: no counter. BUS_WAIT waits indefinitely. RSP_STATUS is always 00.

Test Plan:
- Reset with CMD_VALID=1 held -> all outputs 0. CMD_READY=1 first cycle after RESETN rises. No accept before then.
- RD_REG, ARG=3, HALTED=1, DEBUG_RDATA=0x1234, RSP_READY=1 -> DEBUG_OP=2 for 2 cycles, RSP_VALID on 4th cycle after accept, RSP_DATA=0x1234, status 00.
- RD_MEM, LD_ADDR=1, DATA=0xFFFE, INC=1, BUS_DONE 3 cycles after ISSUE, RDATA=0xBEEF -> RSP_DATA=0xBEEF, DEBUG_ADDR=0x0000 after CAPTURE.
- WR_MEM with HALTED low for 5 cycles -> HALT_REQ=1, DEBUG_OP=0 during wait. After HALTED: DEBUG_WDATA=CMD_DATA, response echoes data.
- RSP_READY low 3 cycles -> RSP_VALID/RSP_DATA stable. A second CMD_VALID is not accepted until the cycle after the handshake.
- With DEBUG_SEQ_TIMEOUT_EN, TIMEOUT_CYC=10, RD_INSTR, no BUS_DONE -> RSP_STATUS=01 and RSP_DATA=0 after 10 BUS_WAIT cycles. DEBUG_ADDR unchanged.
